mem_word_array: RTL and testbench
=================================

Name: mem_word_array

Overview:
- Parametrised, clocked successor to the 8-bit bitcell word: a WIDTH x DEPTH word array with a valid/ready request port and a registered read-response port.
- Adds a per-bit write mask, addressed access, a post-reset hardware clear sweep and an on-demand clear.
- Sits between the memory-cell array level and any requester, and replaces direct sel/rw driving of individual words.

Parameters:
- WIDTH, 8, bits per word (>=1)
- DEPTH, 8, number of words (>=2; need not be a power of two)
- AW, $clog2(DEPTH), address width; derived localparam, not overridable

Ports:
- clk  input  1  single clock, all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  request accepted this cycle when high together with req_valid
- req_rw  input  1  1 = write, 0 = read
- req_addr  input  AW  word address
- req_wdata  input  WIDTH  write data
- req_wmask  input  WIDTH  per-bit write enable, 1 = bit written
- clear_req  input  1  level request to re-run the clear sweep
- rsp_valid  output  1  read data valid
- rsp_ready  input  1  consumer accepts the response
- rsp_data  output  WIDTH  read data
- rsp_err  output  1  the read address was out of range
- busy  output  1  clear sweep in progress

Behaviour:
- Reset: the asynchronous, active-low reset drives all of the following.
  - state=CLEAR, clr_cnt=0
  - rsp_valid=0, rsp_data=0, rsp_err=0
  - busy=1, req_ready=0
  - Storage is not reset directly; the clear sweep zeroes it.
- FSM states: CLEAR, IDLE, RESP.
- CLEAR:
  - Writes 0 to word clr_cnt each cycle; clr_cnt counts 0..DEPTH-1.
  - After the write to word DEPTH-1, the next state is IDLE. The sweep takes exactly DEPTH cycles.
  - busy=1 and req_ready=0 throughout. rsp_valid is forced to 0 on entry.
- req_ready is combinational: high when (state==IDLE and !clear_req) or (state==RESP and rsp_ready and !clear_req).
- IDLE transitions:
  - clear_req=1: go to CLEAR with clr_cnt=0. Clear has priority over a simultaneous request, which is not accepted.
  - Accepted write: mem[addr] <= (mem[addr] & ~wmask) | (wdata & wmask). No response is generated. Stay in IDLE.
  - Accepted read: on the next edge, rsp_valid=1, rsp_data=mem[addr], rsp_err=0. Go to RESP.
- Read latency: 1 cycle from acceptance to rsp_valid.
- Write-then-read: a read accepted the cycle after a write to the same address returns the new data.
- RESP:
  - rsp_valid, rsp_data and rsp_err are held stable while rsp_ready=0. No new request is accepted.
  - On rsp_ready=1, the response completes and a new request may be accepted in the same cycle (back-to-back reads at full rate).
  - Completion with a new read accepted: stay in RESP and load the new data.
  - Completion with a write or no request: rsp_valid=0 and go to IDLE. rsp_data keeps its last value.
  - Completion with clear_req=1: go to CLEAR.
- Out-of-range address (addr>=DEPTH, possible only when DEPTH is not a power of two):
  - Write: discarded, storage unchanged.
  - Read: rsp_data=0 and rsp_err=1.
- Reset asserted mid-sweep or mid-response: immediate return to reset values. The sweep restarts from word 0 after rst_n deasserts.
- clear_req is ignored while in CLEAR. If it is still high at the end of the sweep, IDLE immediately re-enters CLEAR.

Decomposition:
- Shared package holds:
  - FSM state enum {CLEAR, IDLE, RESP}
  - RW encoding constants RW_READ=0, RW_WRITE=1
- One natural sub-module: mem_word_store.
  - Contents: DEPTH x WIDTH register storage with masked write port and combinational read port.
  - The controller FSM, clear counter and response register stay in mem_word_array.

Test Plan:
- Reset release: expect busy=1 for exactly 8 cycles (DEPTH=8), then req_ready=1. A read of every address returns 0x00 with rsp_err=0.
- Masked write: write addr 3 data 0xFF mask 0xFF, then data 0x00 mask 0x0F. A read of addr 3 returns 0xF0, with rsp_valid exactly 1 cycle after acceptance.
- Backpressure: hold rsp_ready=0 for 5 cycles after a read of addr 3.
  - Expect rsp_data=0xF0 held stable and req_ready=0.
  - Then raise rsp_ready with a back-to-back read of addr 0 and expect 0x00 on the next cycle.
- Clear collision: in IDLE, assert clear_req with a write to addr 1 in the same cycle.
  - Expect req_ready=0, the write not accepted and busy=1 for 8 cycles.
  - addr 3 reads 0x00 afterwards.
- Out of range (DEPTH=6): write 0xAA to addr 7, then read addr 7. Expect rsp_data=0x00 and rsp_err=1, with addr 0-5 unchanged.
- Async reset mid-sweep: pull rst_n low at cycle 3 of the sweep. Outputs reset immediately, and after release the sweep takes a full 8 cycles.

Source files
------------

// File: rtl/mem_word_array_pkg.sv
// Shared types and constants for the word array controller and its storage.
package mem_word_array_pkg;

  // Controller states: hardware clear sweep, waiting for a request, holding a read response.
  typedef enum logic [1:0] {
    StClear = 2'd0,
    StIdle  = 2'd1,
    StResp  = 2'd2
  } state_e;

  // Encoding of req_rw.
  localparam logic RwRead  = 1'b0;
  localparam logic RwWrite = 1'b1;

endpackage

// File: rtl/mem_word_store.sv
// DEPTH x WIDTH register storage: one masked write port, one combinational read port.
// Storage is deliberately not reset; the controller zeroes it with a clear sweep.
module mem_word_store #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] wmask,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Next-state of the array: merge masked write data into the addressed word.
  always_comb begin
    mem_d = mem_q;
    if (we && (32'(waddr) < DEPTH)) begin
      mem_d[waddr] = (mem_q[waddr] & ~wmask) | (wdata & wmask);
    end
  end

  // Storage register, no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Combinational read; addresses past the last word read as zero.
  always_comb begin
    rdata = '0;
    if (32'(raddr) < DEPTH) begin
      rdata = mem_q[raddr];
    end
  end

endmodule

// File: rtl/mem_word_array.sv
// Word array controller: valid/ready request port, registered read response,
// post-reset and on-demand clear sweep over the storage.
module mem_word_array
  import mem_word_array_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_rw,
  input  logic [AW-1:0]    req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  input  logic [WIDTH-1:0] req_wmask,
  input  logic             clear_req,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [AW-1:0]    clr_cnt_q, clr_cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;

  logic             st_we;
  logic [AW-1:0]    st_waddr;
  logic [WIDTH-1:0] st_wdata;
  logic [WIDTH-1:0] st_wmask;
  logic [WIDTH-1:0] st_rdata;

  logic             accept;
  logic             addr_ok;
  logic             clr_last;

  // Request handshake; a pending clear_req blocks acceptance so clear wins any collision.
  always_comb begin
    req_ready = ((state_q == StIdle) || ((state_q == StResp) && rsp_ready)) && !clear_req;
    accept    = req_valid && req_ready;
    addr_ok   = 32'(req_addr) < DEPTH;
    clr_last  = clr_cnt_q == AW'(DEPTH - 1);
  end

  // Next-state, storage write port and response register updates.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    st_we       = 1'b0;
    st_waddr    = req_addr;
    st_wdata    = req_wdata;
    st_wmask    = req_wmask;

    unique case (state_q)
      StClear: begin
        st_we       = 1'b1;
        st_waddr    = clr_cnt_q;
        st_wdata    = '0;
        st_wmask    = '1;
        rsp_valid_d = 1'b0;
        if (clr_last) begin
          state_d   = StIdle;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + AW'(1);
        end
      end

      StIdle, StResp: begin
        // A consumed response retires unless a new read reloads it below.
        if ((state_q == StResp) && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
        if (clear_req && ((state_q == StIdle) || rsp_ready)) begin
          state_d     = StClear;
          clr_cnt_d   = '0;
          rsp_valid_d = 1'b0;
        end else if (accept) begin
          if (req_rw == RwWrite) begin
            st_we = addr_ok;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = addr_ok ? st_rdata : '0;
            rsp_err_d   = !addr_ok;
            state_d     = StResp;
          end
        end
      end

      default: begin
        state_d   = StClear;
        clr_cnt_d = '0;
      end
    endcase
  end

  // Controller state and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StClear;
      clr_cnt_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q == StClear);

  mem_word_store #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_store (
    .clk  (clk),
    .we   (st_we),
    .waddr(st_waddr),
    .wdata(st_wdata),
    .wmask(st_wmask),
    .raddr(req_addr),
    .rdata(st_rdata)
  );

endmodule

// File: tb/tb_mem_word_array.sv
// Bench for mem_word_array: a DEPTH=8 instance and a DEPTH=6 instance (out-of-range addresses),
// directed scenarios plus randomized reads/writes checked against a plain array model.
module tb_mem_word_array;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]      req_valid, req_rw, clear_req, rsp_ready;
  logic [1:0][2:0] req_addr;
  logic [1:0][7:0] req_wdata, req_wmask;
  logic [1:0]      req_ready, rsp_valid, rsp_err, busy;
  logic [1:0][7:0] rsp_data;

  int errs = 0;
  int checks = 0;
  logic [7:0] mdl [2][8];
  int depth_of [2] = '{8, 6};

  mem_word_array #(.WIDTH(8), .DEPTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_rw(req_rw[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wmask(req_wmask[0]),
    .clear_req(clear_req[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]), .busy(busy[0])
  );

  mem_word_array #(.WIDTH(8), .DEPTH(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_rw(req_rw[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wmask(req_wmask[1]),
    .clear_req(clear_req[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]), .busy(busy[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_model();
    for (int d = 0; d < 2; d++) for (int a = 0; a < 8; a++) mdl[d][a] = 8'h00;
  endtask

  // Count cycles until busy drops on instance d, bounded.
  task automatic sweep_wait(input int d, input int exp_cycles, input string tag);
    int n = 0;
    while (busy[d] && n < 40) begin
      step();
      n++;
    end
    chk(tag, n, exp_cycles);
    chk({tag, "_ready"}, req_ready[d], 1);
  endtask

  task automatic do_write(input int d, input logic [2:0] a, input logic [7:0] wd,
                          input logic [7:0] wm);
    req_valid[d] = 1'b1;
    req_rw[d]    = 1'b1;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    req_wmask[d] = wm;
    #1;
    chk("wr_ready", req_ready[d], 1);
    step();
    req_valid[d] = 1'b0;
    if (int'(a) < depth_of[d]) mdl[d][a] = (mdl[d][a] & ~wm) | (wd & wm);
    chk("wr_no_rsp", rsp_valid[d], 0);
  endtask

  task automatic do_read(input int d, input logic [2:0] a, input int stall);
    logic [7:0] exp_d;
    logic       exp_e;
    exp_e = !(int'(a) < depth_of[d]);
    exp_d = exp_e ? 8'h00 : mdl[d][a];
    req_valid[d] = 1'b1;
    req_rw[d]    = 1'b0;
    req_addr[d]  = a;
    rsp_ready[d] = 1'b0;
    #1;
    chk("rd_ready", req_ready[d], 1);
    chk("rd_pre_valid", rsp_valid[d], 0);
    step();
    req_valid[d] = 1'b0;
    chk("rd_valid", rsp_valid[d], 1);
    chk("rd_data", rsp_data[d], exp_d);
    chk("rd_err", rsp_err[d], exp_e);
    for (int i = 0; i < stall; i++) begin
      step();
      chk("hold_valid", rsp_valid[d], 1);
      chk("hold_data", rsp_data[d], exp_d);
      chk("hold_ready", req_ready[d], 0);
    end
    rsp_ready[d] = 1'b1;
    #1;
    chk("rsp_done_ready", req_ready[d], 1);
    step();
    chk("rsp_done_valid", rsp_valid[d], 0);
    rsp_ready[d] = 1'b0;
  endtask

  initial begin
    req_valid = '0; req_rw = '0; clear_req = '0; rsp_ready = '0;
    req_addr = '0; req_wdata = '0; req_wmask = '0;

    // Reset state.
    #1 rst_n = 1'b0;
    step();
    step();
    chk("rst_busy", busy[0], 1);
    chk("rst_ready", req_ready[0], 0);
    chk("rst_valid", rsp_valid[0], 0);
    chk("rst_data", rsp_data[0], 0);
    chk("rst_err", rsp_err[0], 0);
    rst_n = 1'b1;
    sweep_wait(0, 8, "sweep_after_reset");
    zero_model();
    for (int a = 0; a < 8; a++) do_read(0, 3'(a), 0);

    // Masked write then readback.
    do_write(0, 3'd3, 8'hFF, 8'hFF);
    do_write(0, 3'd3, 8'h00, 8'h0F);
    do_read(0, 3'd3, 0);

    // Backpressure on addr 3, then back-to-back read of addr 0.
    req_valid[0] = 1'b1; req_rw[0] = 1'b0; req_addr[0] = 3'd3; rsp_ready[0] = 1'b0;
    step();
    req_valid[0] = 1'b0;
    chk("bp_first", rsp_data[0], 8'hF0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_data", rsp_data[0], 8'hF0);
      chk("bp_valid", rsp_valid[0], 1);
      chk("bp_ready", req_ready[0], 0);
    end
    rsp_ready[0] = 1'b1; req_valid[0] = 1'b1; req_addr[0] = 3'd0;
    #1;
    chk("b2b_ready", req_ready[0], 1);
    step();
    req_valid[0] = 1'b0;
    chk("b2b_valid", rsp_valid[0], 1);
    chk("b2b_data", rsp_data[0], 8'h00);
    step();
    chk("b2b_done", rsp_valid[0], 0);
    rsp_ready[0] = 1'b0;

    // Out of range on the DEPTH=6 instance.
    do_write(1, 3'd1, 8'h5A, 8'hFF);
    do_write(1, 3'd7, 8'hAA, 8'hFF);
    do_read(1, 3'd7, 1);
    chk("oor_err_kept", rsp_err[1], 1);
    for (int a = 0; a < 6; a++) do_read(1, 3'(a), 0);

    // Randomized mix on both instances.
    for (int i = 0; i < 150; i++) begin
      int d;
      logic [2:0] a;
      d = int'($urandom_range(0, 1));
      a = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) do_write(d, a, 8'($urandom), 8'($urandom));
      else do_read(d, a, int'($urandom_range(0, 2)));
    end

    // Clear collides with a write: clear wins, write dropped.
    do_write(0, 3'd3, 8'hC3, 8'hFF);
    clear_req[0] = 1'b1;
    req_valid[0] = 1'b1; req_rw[0] = 1'b1; req_addr[0] = 3'd1;
    req_wdata[0] = 8'h55; req_wmask[0] = 8'hFF;
    #1;
    chk("col_ready", req_ready[0], 0);
    step();
    clear_req[0] = 1'b0;
    req_valid[0] = 1'b0;
    chk("col_busy", busy[0], 1);
    for (int a = 0; a < 8; a++) mdl[0][a] = 8'h00;
    sweep_wait(0, 8, "col_sweep");
    do_read(0, 3'd3, 0);
    do_read(0, 3'd1, 0);

    // Async reset mid-sweep; the restarted sweep must cover every word.
    do_write(0, 3'd7, 8'h77, 8'hFF);
    do_read(0, 3'd7, 0);
    clear_req[0] = 1'b1;
    step();
    clear_req[0] = 1'b0;
    chk("clr_keep_data", rsp_data[0], 8'h77);
    chk("clr_valid", rsp_valid[0], 0);
    step();
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy[0], 1);
    chk("mid_rst_ready", req_ready[0], 0);
    chk("mid_rst_data", rsp_data[0], 0);
    chk("mid_rst_valid", rsp_valid[0], 0);
    step();
    rst_n = 1'b1;
    zero_model();
    sweep_wait(0, 8, "mid_rst_sweep");
    do_read(0, 3'd7, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
